rotate_coord_gen: RTL
=====================

ROTATE_COORD_GEN -- requirements
Module: rotate_coord_gen

Interface
REQ-001 SHALL have parameter WIDT_A, default 11: signed coordinate width; matches the A operand width of the downstream multipliers.
REQ-002 SHALL have parameter WIDT_B, default 9: signed sin/cos coefficient width; matches the B operand width of the downstream multipliers.
REQ-003 SHALL have parameter IMG_W, default 1024: active pixels per line.
REQ-004 SHALL have parameter IMG_H, default 768: active lines per frame.
REQ-005 SHALL have port CLK, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port RSTN, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port START, input, 1: frame request; accepted only in IDLE.
REQ-008 SHALL have port ABORT, input, 1: synchronous frame cancel.
REQ-009 SHALL have ports COS_IN and SIN_IN, input, WIDT_B signed: coefficients, sampled on START acceptance.
REQ-010 SHALL have ports X and Y, output, WIDT_A signed: centred coordinates.
REQ-011 SHALL have ports COS and SIN, output, WIDT_B signed: latched coefficients, held for the whole frame.
REQ-012 SHALL have port VALID, output, 1: X/Y/flags valid.
REQ-013 SHALL have port READY, input, 1: downstream accepts.
REQ-014 SHALL have ports SOF, EOL and EOF, output, 1 each: first pixel of frame, last pixel of line, last pixel of frame; qualified by VALID.
REQ-015 SHALL have ports BUSY and DONE, output, 1 each: BUSY = state is not IDLE; DONE = one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, RUN and FIN.
REQ-017 In IDLE with START=1 and ABORT=0, the block SHALL latch COS_IN/SIN_IN, clear col/row to 0 and enter RUN; VALID SHALL rise on the cycle after acceptance.
REQ-018 START SHALL be ignored in RUN and FIN.
REQ-019 X SHALL equal col - IMG_W/2 and Y SHALL equal row - IMG_H/2, both sign-correct at WIDT_A; col and row counters SHALL be $clog2(IMG_W) and $clog2(IMG_H) bits wide respectively.
REQ-020 A transfer SHALL occur when VALID=1 and READY=1; col SHALL advance only on a transfer.
REQ-021 When VALID=1 and READY=0, X, Y, SOF, EOL, EOF and VALID SHALL be held unchanged.
REQ-022 On a transfer at col=IMG_W-1, col SHALL wrap to 0 and row SHALL increment.
REQ-023 SOF SHALL be 1 only at col=0 and row=0.
REQ-024 EOL SHALL be 1 at col=IMG_W-1.
REQ-025 EOF SHALL be 1 at col=IMG_W-1 and row=IMG_H-1.
REQ-026 A transfer with EOF=1 SHALL move the state to FIN and drop VALID the next cycle.
REQ-027 FIN SHALL assert DONE for exactly one cycle and then return to IDLE.
REQ-028 ABORT=1 in any state SHALL go to IDLE on the next edge, with VALID=0, no DONE, and counters cleared; ABORT SHALL win over a simultaneous START or transfer.
REQ-029 VALID SHALL never drop without either a transfer with EOF=1 or ABORT.
REQ-030 A back-to-back frame SHALL be possible: START in the cycle after DONE is accepted.
REQ-031 Elaboration SHALL fail if IMG_W/2 > 2^(WIDT_A-1) or IMG_H/2 > 2^(WIDT_A-1).

Reset
REQ-032 While RSTN=0, the state SHALL be IDLE and VALID, SOF, EOL, EOF, BUSY, DONE, X, Y, COS, SIN and the counters SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame immediately, with no DONE.
REQ-034 After RSTN deasserts, the first START SHALL be acceptable on the first clock edge.

Structure
REQ-035 Package rotate_pkg SHALL hold the state enum (IDLE, RUN, FIN) and the default WIDT_A/WIDT_B constants shared with the multiplier stage.
REQ-036 The col/row counting with wrap and terminal flags SHALL be one sub-module, rotate_scan_cnt; the FSM, handshake and coefficient latch SHALL stay in the top module.

Verification (IMG_W=4, IMG_H=2, WIDT_A=11)
REQ-037 READY held 1, START with COS_IN=127 and SIN_IN=0 -> 8 transfers with X=-2,-1,0,1 and Y=-1 then Y=0; SOF on the 1st, EOL on the 4th and 8th, EOF on the 8th; DONE 2 cycles after the 8th; COS=127 throughout.
REQ-038 READY toggling 1/0 each cycle -> X/Y/flags stable during stalls; still exactly 8 transfers with no duplicated or skipped coordinate.
REQ-039 START pulsed again at transfer 3 -> ignored; COS/SIN unchanged; frame completes normally.
REQ-040 ABORT at transfer 5 together with START -> IDLE next cycle, VALID=0, no DONE, BUSY=0; a later START restarts at X=-2, Y=-1 with SOF=1.
REQ-041 RSTN low for 1 cycle at transfer 6 -> all outputs 0 asynchronously, no DONE; a fresh frame after release is correct.
REQ-042 START on the cycle after DONE -> VALID rises the next cycle and two full frames complete back-to-back.

Source files
------------

// File: rtl/rotate_pkg.sv
// rotate_pkg -- shared definitions for the rotation coordinate path.
//   rot_state_e : frame sequencer states (IDLE, RUN, FIN)
//   ROT_WIDT_A  : default signed coordinate width (multiplier A operand)
//   ROT_WIDT_B  : default signed sin/cos width (multiplier B operand)
package rotate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } rot_state_e;

  localparam int ROT_WIDT_A = 11;
  localparam int ROT_WIDT_B = 9;

endpackage

// File: rtl/rotate_scan_cnt.sv
// rotate_scan_cnt -- raster col/row counter with line wrap and terminal flags.
//   CLK, RSTN : clock, async active-low reset
//   clr       : synchronous clear to col=0,row=0 (wins over adv)
//   adv       : advance one pixel (one downstream transfer)
//   col, row  : current raster position
//   sof/eol/eof : position flags for the current col/row (not valid-qualified)
module rotate_scan_cnt #(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 768,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          sof,
  output logic          eol,
  output logic          eof
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic col_last, row_last;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col_last) begin
        col <= '0;
        // Row also wraps so the counter lands at 0,0 after the last pixel.
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign sof = (col == '0) && (row == '0);
  assign eol = col_last;
  assign eof = col_last && row_last;

endmodule

// File: rtl/rotate_coord_gen.sv
// rotate_coord_gen -- generates centred (x,y) raster coordinates plus the
// frame's latched cos/sin coefficients for a downstream rotation multiplier.
//   CLK, RSTN        : clock, async active-low reset
//   START, ABORT     : frame request (IDLE only) / synchronous cancel
//   COS_IN, SIN_IN   : coefficients, captured when START is accepted
//   X, Y             : col - IMG_W/2, row - IMG_H/2 (signed, WIDT_A)
//   COS, SIN         : latched coefficients, stable for the frame
//   VALID, READY     : valid/ready handshake for X/Y/flags
//   SOF, EOL, EOF    : first pixel / last of line / last of frame
//   BUSY, DONE       : not-IDLE / one-cycle frame completion pulse
module rotate_coord_gen
  import rotate_pkg::*;
#(
  parameter int WIDT_A = ROT_WIDT_A,
  parameter int WIDT_B = ROT_WIDT_B,
  parameter int IMG_W  = 1024,
  parameter int IMG_H  = 768
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic signed [WIDT_B-1:0] COS_IN,
  input  logic signed [WIDT_B-1:0] SIN_IN,
  output logic signed [WIDT_A-1:0] X,
  output logic signed [WIDT_A-1:0] Y,
  output logic signed [WIDT_B-1:0] COS,
  output logic signed [WIDT_B-1:0] SIN,
  output logic                     VALID,
  input  logic                     READY,
  output logic                     SOF,
  output logic                     EOL,
  output logic                     EOF,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  // Centred coordinates must fit the signed multiplier operand.
  if ((IMG_W / 2) > (2 ** (WIDT_A - 1)) || (IMG_H / 2) > (2 ** (WIDT_A - 1)))
  begin : g_bad_size
    $error("rotate_coord_gen: IMG_W/2 or IMG_H/2 exceeds 2^(WIDT_A-1)");
  end

  rot_state_e state, state_nx;

  logic          vld;
  logic          done_q;
  logic [WIDT_B-1:0] cos_q, sin_q;
  logic          accept, xfer;
  logic          cnt_clr, cnt_adv;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          sof, eol, eof;

  assign accept = (state == IDLE) && START && !ABORT;
  assign xfer   = vld && READY;

  // Next state; ABORT overrides everything else.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START)      state_nx = RUN;
      RUN:     if (xfer && eof) state_nx = FIN;
      FIN:                     state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
    if (ABORT) state_nx = IDLE;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      vld    <= 1'b0;
      done_q <= 1'b0;
      cos_q  <= '0;
      sin_q  <= '0;
    end else begin
      state  <= state_nx;
      // VALID tracks RUN one-to-one; registered so it rises the cycle after
      // acceptance and falls the cycle after the EOF transfer.
      vld    <= (state_nx == RUN);
      // DONE follows FIN by one cycle, so it lands two cycles after the
      // EOF transfer and never on an aborted frame.
      done_q <= (state == FIN) && !ABORT;
      if (accept) begin
        cos_q <= COS_IN;
        sin_q <= SIN_IN;
      end
    end
  end

  assign cnt_clr = ABORT || accept;
  assign cnt_adv = xfer;

  rotate_scan_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_scan (
    .CLK  (CLK),
    .RSTN (RSTN),
    .clr  (cnt_clr),
    .adv  (cnt_adv),
    .col  (col),
    .row  (row),
    .sof  (sof),
    .eol  (eol),
    .eof  (eof)
  );

  // Outputs are derived from held registers, so a stall (READY=0) keeps them
  // unchanged. Gating with VALID keeps them at 0 outside a frame and in reset.
  logic [WIDT_A-1:0] xc, yc;
  assign xc = WIDT_A'(col) - WIDT_A'(IMG_W / 2);
  assign yc = WIDT_A'(row) - WIDT_A'(IMG_H / 2);

  assign X     = vld ? $signed(xc) : '0;
  assign Y     = vld ? $signed(yc) : '0;
  assign SOF   = vld && sof;
  assign EOL   = vld && eol;
  assign EOF   = vld && eof;
  assign VALID = vld;
  assign COS   = $signed(cos_q);
  assign SIN   = $signed(sin_q);
  assign BUSY  = (state != IDLE);
  assign DONE  = done_q;

endmodule
